// File: rtl/adc_pkg.sv
// Shared constants and types for the ADC sample path.
// Width, channel encodings and the signed sample type.
package adc_pkg;

  localparam int ADC_DATA_W = 24;

  localparam logic CH1 = 1'b0;
  localparam logic CH2 = 1'b1;

  typedef logic signed [ADC_DATA_W-1:0] sample_t;

endpackage

// File: rtl/avg_out_fifo.sv
// Two-entry result FIFO between the averager and its consumer.
// A pop in the same cycle frees the slot for a push when full.
module avg_out_fifo #(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count;
  logic         do_pop;
  logic         do_push;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clear) begin
      // Head slot is left untouched so dout holds its last value.
      wr_ptr <= rd_ptr;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop)
        rd_ptr <= ~rd_ptr;
      unique case (1'b1)
        do_push && !do_pop: count <= count + 2'd1;
        do_pop && !do_push: count <= count - 2'd1;
        default:            count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adc_sample_averager.sv
// Per-channel boxcar averager for the dual-channel ADC stream.
// Emits one floor-rounded mean per 2^AVG_LOG2 samples into a 2-deep buffer.
module adc_sample_averager
  import adc_pkg::*;
#(
  parameter int DATA_W   = ADC_DATA_W,
  parameter int AVG_LOG2 = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_channel,
  input  logic              in_valid,
  input  logic              enable,
  input  logic              clear,
  output logic [DATA_W-1:0] out_data,
  output logic              out_channel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic              busy
);

  localparam int N  = 1 << AVG_LOG2;
  localparam int AW = DATA_W + AVG_LOG2;
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic signed [AW-1:0]     acc [2];
  logic [CW-1:0]            cnt [2];
  logic [CW-1:0]            cnt_nxt [2];
  logic                     ch;
  logic                     accept;
  logic                     last;
  logic signed [AW-1:0]     sext;
  logic signed [AW-1:0]     sum;
  logic signed [DATA_W-1:0] avg;
  logic                     push;
  logic                     pop;
  logic                     full;
  logic                     empty;
  logic [DATA_W:0]          head;

  always_comb begin
    ch     = (in_channel == CH2);
    accept = in_valid && enable && !clear;
    sext   = AW'($signed(in_data));
    sum    = acc[ch] + sext;
    // Arithmetic shift floors negative means.
    avg    = DATA_W'(sum >>> AVG_LOG2);
    last   = (AVG_LOG2 == 0) || (cnt[ch] == LAST);
    push   = accept && last;
    cnt_nxt[0] = cnt[0];
    cnt_nxt[1] = cnt[1];
    if (accept)
      cnt_nxt[ch] = last ? '0 : cnt[ch] + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc[0] <= '0;
      acc[1] <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
      busy   <= 1'b0;
    end else if (clear) begin
      acc[0] <= '0;
      acc[1] <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
      busy   <= 1'b0;
    end else begin
      if (accept)
        acc[ch] <= last ? '0 : sum;
      cnt[0] <= cnt_nxt[0];
      cnt[1] <= cnt_nxt[1];
      busy   <= (cnt_nxt[0] != '0) || (cnt_nxt[1] != '0);
    end
  end

  assign pop = out_ready && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      overrun <= 1'b0;
    else if (clear)
      overrun <= 1'b0;
    else if (push && full && !pop)
      overrun <= 1'b1;
  end

  avg_out_fifo #(
    .W (DATA_W + 1)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push),
    .din   ({in_channel, avg}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign out_valid   = !empty;
  assign out_channel = head[DATA_W];
  assign out_data    = head[DATA_W-1:0];

endmodule

// File: tb/tb_adc_sample_averager.sv
// Scoreboard bench for adc_sample_averager: directed cases plus random traffic.
// Expected means come from running sums and floor division per channel.
module tb_adc_sample_averager;

  localparam int DW = 24;
  localparam int AL = 3;
  localparam int NS = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_channel = 1'b0;
  logic          in_valid = 1'b0;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_channel;
  logic          out_valid;
  logic          overrun;
  logic          busy;

  adc_sample_averager #(
    .DATA_W   (DW),
    .AVG_LOG2 (AL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_channel  (in_channel),
    .in_valid    (in_valid),
    .enable      (enable),
    .clear       (clear),
    .out_data    (out_data),
    .out_channel (out_channel),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          c;
  } res_t;

  int     vectors = 0;
  int     miscompares = 0;
  res_t   exp_q[$];
  int     mocc = 0;
  bit     movr = 1'b0;
  longint msum [2];
  int     mcnt [2];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    mocc    = 0;
    movr    = 1'b0;
    msum[0] = 0;
    msum[1] = 0;
    mcnt[0] = 0;
    mcnt[1] = 0;
  endtask

  function automatic longint floor_mean(input longint s);
    longint q;
    q = s / NS;
    if (s < 0 && (s % NS) != 0)
      q = q - 1;
    return q;
  endfunction

  task automatic model_step(input logic v, input logic c, input logic [DW-1:0] d,
                            input logic en, input logic clr, input logic rdy);
    bit     was_full;
    bit     popm;
    longint m;
    int     ci;
    res_t   r;
    if (clr) begin
      model_reset();
      return;
    end
    ci       = int'(c);
    was_full = (mocc == 2);
    popm     = (mocc > 0) && rdy;
    if (popm)
      mocc--;
    if (v && en) begin
      msum[ci] += longint'($signed(d));
      mcnt[ci]++;
      if (mcnt[ci] == NS) begin
        m        = floor_mean(msum[ci]);
        msum[ci] = 0;
        mcnt[ci] = 0;
        if (!was_full || popm) begin
          r.d = m[DW-1:0];
          r.c = c;
          exp_q.push_back(r);
          mocc++;
        end else begin
          movr = 1'b1;
        end
      end
    end
  endtask

  task automatic cyc(input logic v, input logic c, input logic [DW-1:0] d,
                     input logic en, input logic clr, input logic rdy);
    in_valid   = v;
    in_channel = c;
    in_data    = d;
    enable     = en;
    clear      = clr;
    out_ready  = rdy;
    @(posedge clk);
    model_step(v, c, d, en, clr, rdy);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, rdy);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_channel"}, out_channel, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Monitor: compares the buffer head whenever a handshake happens.
  logic          pv = 1'b0;
  logic          pr = 1'b0;
  logic [DW-1:0] pd = '0;
  res_t          e;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("out_valid", out_valid, mocc != 0);
        chk("overrun", overrun, movr);
        chk("busy", busy, (mcnt[0] != 0) || (mcnt[1] != 0));
        if (pv && !pr && out_valid)
          chk("hold_data", out_data, pd);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_out: got %0h expected none", out_data);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", out_data, e.d);
            chk("out_channel", out_channel, e.c);
          end
        end
      end
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1;
    check_zero("rst_hold");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2, 1'b1);
    check_zero("post_rst");

    // ch1 samples 1..8 average to 4
    for (int i = 1; i <= 8; i++)
      cyc(1'b1, 1'b0, DW'(i), 1'b1, 1'b0, 1'b1);
    idle(3, 1'b1);

    // interleaved channels, full-scale positive on ch2
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, DW'(-5), 1'b1, 1'b0, 1'b1);
      cyc(1'b1, 1'b1, 24'h7FFFFF, 1'b1, 1'b0, 1'b1);
    end
    idle(3, 1'b1);

    // stalled consumer: third result dropped
    for (int i = 0; i < 24; i++)
      cyc(1'b1, 1'b0, DW'(i * 3 - 20), 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(4, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);

    // full buffer popped in the same cycle as the third push
    for (int i = 0; i < 23; i++)
      cyc(1'b1, 1'b1, DW'(i * 1000), 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, DW'(77), 1'b1, 1'b0, 1'b1);
    idle(4, 1'b1);

    // clear wins over the final strobe
    for (int i = 0; i < 7; i++)
      cyc(1'b1, 1'b0, DW'(10), 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, DW'(10), 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 1'b0, DW'(2), 1'b1, 1'b0, 1'b1);
    idle(3, 1'b1);

    // enable low is ignored
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 1'b1, DW'(i), 1'b0, 1'b0, 1'b1);
    idle(2, 1'b1);

    // async reset mid-accumulation with a result pending
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 1'b1, DW'(-100), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b0, DW'(9), 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 1'b0, DW'(-i), 1'b1, 1'b0, 1'b1);
    idle(3, 1'b1);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      logic [DW-1:0] d;
      if ($urandom_range(0, 1) == 0)
        d = DW'($urandom());
      else
        d = DW'(int'($urandom_range(0, 15)) - 8);
      cyc($urandom_range(0, 99) < 70, 1'($urandom_range(0, 1)), d,
          $urandom_range(0, 99) < 90, $urandom_range(0, 199) == 0,
          $urandom_range(0, 99) < 60);
    end
    idle(6, 1'b1);
    chk("drain_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
